sc_frame_gate: RTL and testbench

Parametrised Schmidl & Cox frame gate for the RFNoC OFDM receive chain. It sits between the timing-metric correlator and the FFT. It consumes the sample stream and its time-aligned metric stream in lockstep and qualifies a detection over several consecutive samples. It tracks the metric peak, then forwards one frame of `frame_length` samples starting `peak_offset` samples after the peak. It adds RFNoC packetisation, a post-frame holdoff and backpressure-correct joint handshaking.

---
 rtl/sc_frame_gate.sv | 250 +++++++++++++++++++++++++
 tb/tb_sc_frame_gate.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_frame_gate.sv
// sc_frame_gate -- Schmidl & Cox frame gate.
//
// Consumes a sample stream and its time-aligned timing-metric stream in
// lockstep. Qualifies a detection after min_above consecutive beats above
// threshold and tracks the metric peak. It then forwards frame_length
// samples, starting peak_offset beats after the last maximal peak beat.
// Output is packetised every spp beats. A holdoff follows each frame.
//
// Optional feature macro: SC_FRAME_GATE_PEAK_REPORT_EN
//   When defined, adds peak_value (captured peak) and peak_valid (pulse
//   coincident with frame_start).
//
// Ports:
//   clk, reset, clear          clock, sync active-high reset / clear
//   threshold, min_above       detection threshold (live), qualification run
//   peak_offset, frame_length  peak-to-frame delay, frame size (0 -> 1)
//   spp, holdoff               packet size (0 -> 1), post-frame ignore beats
//   gate_mode                  0: zeros outside frame, 1: drop outside frame
//   m_*                        metric stream (AXI-Stream, input)
//   i_*                        sample stream (AXI-Stream, input)
//   o_*                        gated sample stream (AXI-Stream, output)
//   frame_start, frame_end     registered one-cycle pulses
//   frame_count                completed frames (wraps)
//   state                      current FSM state encoding
module sc_frame_gate #(
  parameter int unsigned SAMPLE_WIDTH = 32,
  parameter int unsigned METRIC_WIDTH = 32,
  parameter int unsigned COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [METRIC_WIDTH-1:0] threshold,
  input  logic [7:0]              min_above,
  input  logic [COUNT_WIDTH-1:0]  peak_offset,
  input  logic [COUNT_WIDTH-1:0]  frame_length,
  input  logic [15:0]             spp,
  input  logic [COUNT_WIDTH-1:0]  holdoff,
  input  logic                    gate_mode,
  input  logic [METRIC_WIDTH-1:0] m_tdata,
  input  logic                    m_tvalid,
  output logic                    m_tready,
  input  logic [SAMPLE_WIDTH-1:0] i_tdata,
  input  logic                    i_tlast,
  input  logic                    i_tvalid,
  output logic                    i_tready,
  output logic [SAMPLE_WIDTH-1:0] o_tdata,
  output logic                    o_tlast,
  output logic                    o_tvalid,
  input  logic                    o_tready,
  output logic                    frame_start,
  output logic                    frame_end,
  output logic [15:0]             frame_count,
  output logic [2:0]              state
`ifdef SC_FRAME_GATE_PEAK_REPORT_EN
  ,
  output logic [METRIC_WIDTH-1:0] peak_value,
  output logic                    peak_valid
`endif
);

  typedef enum logic [2:0] {
    ST_SEARCH  = 3'd0,
    ST_TRACK   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_FORWARD = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic                    en_q;
  logic [7:0]              above_q, above_d;
  logic [METRIC_WIDTH-1:0] peak_q, peak_d;
  logic [COUNT_WIDTH-1:0]  cd_q, cd_d;
  logic [COUNT_WIDTH-1:0]  flen_q, flen_d;
  logic [COUNT_WIDTH-1:0]  fpos_q, fpos_d;
  logic [15:0]             spp_q, spp_d;
  logic [15:0]             spos_q, spos_d;
  logic [COUNT_WIDTH-1:0]  hold_q, hold_d;
  logic [15:0]             fcount_q, fcount_d;
  logic                    fstart_q, fstart_d;
  logic                    fend_q, fend_d;

  logic                    rst;
  logic                    en;
  logic                    in_fwd;
  logic                    drop;
  logic                    adv;
  logic                    beat;
  logic                    above;
  logic [7:0]              min_eff;
  logic [COUNT_WIDTH-1:0]  off_m1;
  logic [COUNT_WIDTH-1:0]  flen_eff;
  logic [15:0]             spp_eff;
  logic                    last_beat;
  logic                    spp_last;
  logic                    fwd_tlast;
  logic [COUNT_WIDTH-1:0]  cd_dec;
  logic [COUNT_WIDTH-1:0]  hold_dec;
  logic                    go_fwd;

  assign rst = reset | clear;
  // Readies and valids also drop in the reset cycle itself, not just after.
  assign en     = en_q & ~rst;
  assign in_fwd = (state_q == ST_FORWARD);
  assign drop   = gate_mode & ~in_fwd;
  assign adv    = drop | o_tready;
  assign beat   = m_tvalid & i_tvalid & adv & en;
  assign above  = (m_tdata > threshold);

  assign min_eff  = (min_above == 8'd0) ? 8'd1 : min_above;
  // Countdown is loaded with offset-1 so the first forwarded beat lands
  // exactly peak_offset beats after the peak beat; 0 means forward next beat.
  assign off_m1   = (peak_offset == '0) ? '0 : peak_offset - COUNT_WIDTH'(1);
  assign flen_eff = (frame_length == '0) ? COUNT_WIDTH'(1) : frame_length;
  assign spp_eff  = (spp == 16'd0) ? 16'd1 : spp;

  assign last_beat = (fpos_q == flen_q - COUNT_WIDTH'(1));
  assign spp_last  = (spos_q == spp_q - 16'd1);
  assign fwd_tlast = last_beat | spp_last;
  assign cd_dec    = (cd_q == '0) ? '0 : cd_q - COUNT_WIDTH'(1);
  assign hold_dec  = (hold_q == '0) ? '0 : hold_q - COUNT_WIDTH'(1);

  assign i_tready = m_tvalid & adv & en;
  assign m_tready = i_tvalid & adv & en;
  assign o_tvalid = m_tvalid & i_tvalid & en & ~drop;
  assign o_tdata  = in_fwd ? i_tdata : '0;
  assign o_tlast  = in_fwd ? fwd_tlast : i_tlast;

  always_comb begin
    state_d  = state_q;
    above_d  = above_q;
    peak_d   = peak_q;
    cd_d     = cd_q;
    flen_d   = flen_q;
    fpos_d   = fpos_q;
    spp_d    = spp_q;
    spos_d   = spos_q;
    hold_d   = hold_q;
    fcount_d = fcount_q;
    fstart_d = 1'b0;
    fend_d   = 1'b0;
    go_fwd   = 1'b0;

    if (beat) begin
      unique case (state_q)
        ST_SEARCH: begin
          if (above) begin
            if (({1'b0, above_q} + 9'd1) >= {1'b0, min_eff}) begin
              above_d = '0;
              peak_d  = m_tdata;
              cd_d    = off_m1;
              if (off_m1 == '0) go_fwd = 1'b1;
              else              state_d = ST_TRACK;
            end else begin
              above_d = above_q + 8'd1;
            end
          end else begin
            above_d = '0;
          end
        end
        ST_TRACK: begin
          if (above && (m_tdata >= peak_q)) begin
            peak_d = m_tdata;
            cd_d   = off_m1;
            if (off_m1 == '0) go_fwd = 1'b1;
          end else begin
            cd_d = cd_dec;
            // Countdown expiry wins over the drop to WAIT.
            if (cd_dec == '0)  go_fwd = 1'b1;
            else if (!above)   state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          cd_d = cd_dec;
          if (cd_dec == '0) go_fwd = 1'b1;
        end
        ST_FORWARD: begin
          fpos_d = fpos_q + COUNT_WIDTH'(1);
          spos_d = fwd_tlast ? 16'd0 : spos_q + 16'd1;
          if (fpos_q == '0) fstart_d = 1'b1;
          if (last_beat) begin
            fend_d   = 1'b1;
            fcount_d = fcount_q + 16'd1;
            fpos_d   = '0;
            spos_d   = 16'd0;
            hold_d   = holdoff;
            state_d  = (holdoff == '0) ? ST_SEARCH : ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          hold_d = hold_dec;
          if (hold_dec == '0) state_d = ST_SEARCH;
        end
        default: state_d = ST_SEARCH;
      endcase
    end

    if (go_fwd) begin
      state_d = ST_FORWARD;
      flen_d  = flen_eff;
      spp_d   = spp_eff;
      fpos_d  = '0;
      spos_d  = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_SEARCH;
      en_q     <= 1'b0;
      above_q  <= '0;
      peak_q   <= '0;
      cd_q     <= '0;
      flen_q   <= '0;
      fpos_q   <= '0;
      spp_q    <= '0;
      spos_q   <= '0;
      hold_q   <= '0;
      fcount_q <= '0;
      fstart_q <= 1'b0;
      fend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= 1'b1;
      above_q  <= above_d;
      peak_q   <= peak_d;
      cd_q     <= cd_d;
      flen_q   <= flen_d;
      fpos_q   <= fpos_d;
      spp_q    <= spp_d;
      spos_q   <= spos_d;
      hold_q   <= hold_d;
      fcount_q <= fcount_d;
      fstart_q <= fstart_d;
      fend_q   <= fend_d;
    end
  end

  assign frame_start = fstart_q;
  assign frame_end   = fend_q;
  assign frame_count = fcount_q;
  assign state       = state_q;

`ifdef SC_FRAME_GATE_PEAK_REPORT_EN
  assign peak_value = peak_q;
  assign peak_valid = fstart_q;
`endif

endmodule

// File: tb/tb_sc_frame_gate.sv
// Testbench for sc_frame_gate: directed scenarios plus randomized streams,
// checked against a beat-indexed reference model of the frame gate rules.
module tb_sc_frame_gate;

  localparam int MAXN = 200;

  logic        clk = 1'b0;
  logic        reset, clear;
  logic [31:0] threshold;
  logic [7:0]  min_above;
  logic [15:0] peak_offset, frame_length, spp, holdoff;
  logic        gate_mode;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tready;
  logic [31:0] i_tdata;
  logic        i_tlast, i_tvalid, i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast, o_tvalid, o_tready;
  logic        frame_start, frame_end;
  logic [15:0] frame_count;
  logic [2:0]  state;
`ifdef SC_FRAME_GATE_PEAK_REPORT_EN
  logic [31:0] peak_value;
  logic        peak_valid;
`endif

  sc_frame_gate #(.SAMPLE_WIDTH(32), .METRIC_WIDTH(32), .COUNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .threshold(threshold), .min_above(min_above), .peak_offset(peak_offset),
    .frame_length(frame_length), .spp(spp), .holdoff(holdoff), .gate_mode(gate_mode),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .frame_start(frame_start), .frame_end(frame_end),
    .frame_count(frame_count), .state(state)
`ifdef SC_FRAME_GATE_PEAK_REPORT_EN
    , .peak_value(peak_value), .peak_valid(peak_valid)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] met [MAXN];
  logic [31:0] dat [MAXN];
  logic        lst [MAXN];
  logic [32:0] exp_q [$];
  int exp_frames, exp_starts;
  int n_checks = 0;
  int n_pass = 0;
  int out_cnt, last_cnt, start_cnt, end_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    assert (got === expv) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, expv);
  endtask

  // Reference model: walks the beat sequence using index arithmetic.
  // A frame starts exactly off beats after the last maximal peak seen while
  // the metric stays above threshold following qualification.
  task automatic build_model(input int n);
    int fpos [MAXN];
    int i, run, mn, off, len, sp, hold, p, j, s;
    bit tracking;
    exp_q.delete();
    exp_frames = 0;
    exp_starts = 0;
    for (int k = 0; k < n; k++) fpos[k] = -1;
    mn   = (min_above == 0) ? 1 : int'(min_above);
    off  = (peak_offset == 0) ? 1 : int'(peak_offset);
    len  = (frame_length == 0) ? 1 : int'(frame_length);
    sp   = (spp == 0) ? 1 : int'(spp);
    hold = int'(holdoff);
    i = 0;
    run = 0;
    while (i < n) begin
      if (met[i] > threshold) run++;
      else run = 0;
      if (run < mn) begin
        i++;
        continue;
      end
      p = i;
      j = i + 1;
      tracking = 1'b1;
      while (j < n && j != p + off) begin
        if (tracking) begin
          if (met[j] > threshold) begin
            if (met[j] >= met[p]) p = j;
          end else begin
            tracking = 1'b0;
          end
        end
        j++;
      end
      s = j;
      if (s >= n) break;
      exp_starts++;
      for (int k = 0; k < len; k++) if (s + k < n) fpos[s + k] = k;
      if (s + len <= n) exp_frames++;
      i = s + len + hold;
      run = 0;
    end
    for (int k = 0; k < n; k++) begin
      if (fpos[k] >= 0)
        exp_q.push_back({(((fpos[k] + 1) % sp) == 0) || (fpos[k] == len - 1), dat[k]});
      else if (gate_mode == 1'b0)
        exp_q.push_back({lst[k], 32'h0});
    end
  endtask

  task automatic monitor();
    logic ih, mh;
    logic [32:0] e;
    ih = i_tvalid & i_tready;
    mh = m_tvalid & m_tready;
    if (ih | mh) chk("joint_hs", ih, mh);
    if (o_tvalid & o_tready) begin
      out_cnt++;
      if (o_tlast) last_cnt++;
      chk("out_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_beat", {o_tlast, o_tdata}, e);
      end
    end
    if (frame_start) start_cnt++;
    if (frame_end) end_cnt++;
`ifdef SC_FRAME_GATE_PEAK_REPORT_EN
    if (peak_valid | frame_start) chk("peak_valid", peak_valid, frame_start);
`endif
  endtask

  // Entered and left at posedge+1.
  task automatic apply_reset(input bit use_clear);
    if (use_clear) clear = 1'b1;
    else reset = 1'b1;
    i_tvalid = 1'b1;
    m_tvalid = 1'b1;
    o_tready = 1'b1;
    @(negedge clk);
    chk("rst_otvalid", o_tvalid, 0);
    chk("rst_irdy", i_tready, 0);
    chk("rst_mrdy", m_tready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    chk("rel_irdy", i_tready, 0);
    chk("rel_state", state, 0);
    chk("rel_fcount", frame_count, 0);
    chk("rel_fstart", frame_start, 0);
    chk("rel_fend", frame_end, 0);
    @(posedge clk); #1;
    i_tvalid = 1'b0;
    m_tvalid = 1'b0;
    out_cnt = 0;
    last_cnt = 0;
    start_cnt = 0;
    end_cnt = 0;
  endtask

  task automatic run_stream(input int n, input bit bp, input bit use_clear);
    int idx;
    int budget;
    build_model(n);
    apply_reset(use_clear);
    idx = 0;
    budget = n * 12 + 50;
    while (idx < n && budget > 0) begin
      i_tvalid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_tvalid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      o_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      i_tdata  = dat[idx];
      i_tlast  = lst[idx];
      m_tdata  = met[idx];
      @(negedge clk);
      monitor();
      if (i_tvalid && i_tready) idx++;
      @(posedge clk); #1;
      budget--;
    end
    chk("beats_consumed", idx, n);
    i_tvalid = 1'b0;
    m_tvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      monitor();
      @(posedge clk); #1;
    end
    chk("leftover_outputs", exp_q.size(), 0);
    chk("frame_count", frame_count, exp_frames);
    chk("frame_starts", start_cnt, exp_starts);
    chk("frame_ends", end_cnt, exp_frames);
  endtask

  task automatic set_cfg(input int thr, input int mn, input int off, input int len,
                         input int sp, input int hold, input bit mode);
    threshold    = 32'(thr);
    min_above    = 8'(mn);
    peak_offset  = 16'(off);
    frame_length = 16'(len);
    spp          = 16'(sp);
    holdoff      = 16'(hold);
    gate_mode    = mode;
  endtask

  task automatic fill_data(input int n, input int fill_met);
    for (int k = 0; k < n; k++) begin
      met[k] = 32'(fill_met);
      dat[k] = $urandom;
      lst[k] = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int fwd, idx, budget, n;
    reset = 1'b1;
    clear = 1'b0;
    i_tvalid = 1'b0;
    m_tvalid = 1'b0;
    o_tready = 1'b0;
    i_tdata = '0;
    i_tlast = 1'b0;
    m_tdata = '0;
    set_cfg(15, 2, 4, 8, 4, 0, 1'b1);
    @(posedge clk); #1;

    // Basic frame
    set_cfg(15, 2, 4, 8, 4, 0, 1'b1);
    fill_data(30, 5);
    met[0] = 10; met[1] = 20; met[2] = 30; met[3] = 20; met[4] = 5;
    run_stream(30, 1'b0, 1'b0);
    chk("basic_out_count", out_cnt, 8);
    chk("basic_tlast_count", last_cnt, 2);
    chk("basic_fcount", frame_count, 1);
    run_stream(30, 1'b1, 1'b1);

    // Qualification: isolated above-threshold beat is not enough
    set_cfg(15, 3, 2, 4, 2, 0, 1'b1);
    fill_data(20, 10);
    met[1] = 50;
    run_stream(20, 1'b0, 1'b0);
    chk("qual_state", state, 0);
    chk("qual_no_out", out_cnt, 0);

    // Plateau: latest equal sample is the peak
    set_cfg(15, 1, 3, 4, 0, 0, 1'b1);
    fill_data(24, 5);
    met[1] = 40; met[2] = 40; met[3] = 40;
    run_stream(24, 1'b0, 1'b0);
    // Late peak: new maximum in TRACK reloads the countdown
    fill_data(24, 5);
    met[1] = 40; met[2] = 30; met[3] = 50; met[4] = 30; met[5] = 35;
    run_stream(24, 1'b0, 1'b0);
    run_stream(24, 1'b1, 1'b0);

    // Holdoff with mode 0 and a metric that stays high after the frame
    set_cfg(30, 1, 2, 4, 2, 16, 1'b0);
    fill_data(60, 50);
    met[0] = 5;
    run_stream(60, 1'b0, 1'b0);
    run_stream(60, 1'b1, 1'b1);

    // Reset during frame beat 3
    set_cfg(15, 2, 4, 8, 4, 0, 1'b1);
    fill_data(30, 5);
    met[0] = 10; met[1] = 20; met[2] = 30; met[3] = 20; met[4] = 5;
    apply_reset(1'b0);
    idx = 0;
    fwd = 0;
    budget = 100;
    while (fwd < 2 && budget > 0) begin
      i_tvalid = 1'b1;
      m_tvalid = 1'b1;
      o_tready = 1'b1;
      i_tdata = dat[idx];
      i_tlast = lst[idx];
      m_tdata = met[idx];
      @(negedge clk);
      if (o_tvalid && o_tready) fwd++;
      if (i_tvalid && i_tready) idx++;
      @(posedge clk); #1;
      budget--;
    end
    chk("mid_reached_beat3", fwd, 2);
    i_tdata = dat[idx];
    i_tlast = lst[idx];
    m_tdata = met[idx];
    reset = 1'b1;
    @(negedge clk);
    chk("mid_state_fwd", state, 3);
    chk("mid_otvalid", o_tvalid, 0);
    chk("mid_irdy", i_tready, 0);
    chk("mid_mrdy", m_tready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rel_irdy", i_tready, 0);
    chk("mid_rel_mrdy", m_tready, 0);
    chk("mid_rel_otvalid", o_tvalid, 0);
    chk("mid_rel_fend", frame_end, 0);
    chk("mid_rel_state", state, 0);
    chk("mid_rel_fcount", frame_count, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_en_irdy", i_tready, 1);
    chk("mid_en_fend", frame_end, 0);
    chk("mid_en_state", state, 0);
    @(posedge clk); #1;
    i_tvalid = 1'b0;
    m_tvalid = 1'b0;

    // Randomized configurations, each run stall-free and with backpressure
    for (int r = 0; r < 6; r++) begin
      set_cfg($urandom_range(40, 80), $urandom_range(0, 3), $urandom_range(0, 6),
              $urandom_range(0, 12), $urandom_range(0, 5), $urandom_range(0, 8),
              1'($urandom_range(0, 1)));
      n = $urandom_range(80, 150);
      fill_data(n, 0);
      for (int k = 0; k < n; k++) met[k] = $urandom_range(0, 100);
      run_stream(n, 1'b0, 1'b0);
      run_stream(n, 1'b1, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
